// File: rtl/hpdmc_rdcapture.sv
// hpdmc_rdcapture -- DDR read-data capture with a first-word-fall-through FIFO.
//
// Each accepted read_start is one READ with a burst of 8 DDR beats. That is
// 4 sys_clk cycles of {di_r, di_f}. Capture starts CAS_CYCLES cycles after
// the accept. Captured words go into a FIFO_DEPTH-word FWFT FIFO. rd_ready
// is only given when the FIFO has 4 free slots beyond the words that accepted
// reads have already reserved, so a push never finds the FIFO full.
//
// Ports:
//   sys_clk, sys_rst_n       clock; asynchronous active-low reset
//   read_start / rd_ready    one-cycle READ issued / start would be accepted
//   di_r, di_f               rising/falling halves from the input DDR registers
//   dout, dout_valid         FIFO head word and its valid flag (zero when empty)
//   dout_ready               consumer pop strobe
//   err                      sticky: read_start arrived while rd_ready was low
//   burst_count              (HPDMC_RDCAPTURE_STATS_EN only) saturating count of
//                            completed bursts
//
// Optional feature macro: HPDMC_RDCAPTURE_STATS_EN
module hpdmc_rdcapture #(
    parameter int CAS_CYCLES = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        read_start,
    output logic        rd_ready,
    input  logic [15:0] di_r,
    input  logic [15:0] di_f,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
`ifdef HPDMC_RDCAPTURE_STATS_EN
    output logic [15:0] burst_count,
`endif
    output logic        err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int SRL = CAS_CYCLES + 4;

    // win[k] is set when a read was accepted k cycles ago.
    // win[0] is the accept happening this cycle.
    logic [SRL-1:1] win_q, win_d;
    logic [SRL-1:0] win;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d, resv_q, resv_d, avail;
    logic           err_q, err_d;
    logic           accept, push, pop, recent;
    logic [31:0]    mem [FIFO_DEPTH];

    assign win    = {win_q, accept};
    assign push   = |win[CAS_CYCLES+3:CAS_CYCLES];
    assign recent = |win_q[3:1];
    // Unreserved free slots. resv never exceeds the free space, so this cannot underflow.
    assign avail  = CW'(FIFO_DEPTH) - cnt_q - resv_q;

    always_comb begin
        rd_ready   = sys_rst_n & ~recent & (avail >= CW'(4));
        accept     = read_start & rd_ready;
        dout_valid = (cnt_q != '0);
        pop        = dout_valid & dout_ready;
        dout       = dout_valid ? mem[rd_ptr_q] : 32'h0;

        win_d    = win[SRL-2:0];
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        resv_d   = resv_q + (accept ? CW'(4) : CW'(0)) - CW'(push);
        err_d    = err_q | (read_start & ~rd_ready);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            resv_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            resv_q   <= resv_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset. Stale contents are never visible, because
    // dout is forced to zero while the FIFO is empty.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_q] <= {di_r, di_f};
    end

    assign err = err_q;

`ifdef HPDMC_RDCAPTURE_STATS_EN
    logic [15:0] bcnt_q, bcnt_d;

    // win[CAS_CYCLES+3] marks the cycle that pushes a burst's 4th word.
    always_comb begin
        bcnt_d = bcnt_q;
        if (win[CAS_CYCLES+3] && bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) bcnt_q <= '0;
        else            bcnt_q <= bcnt_d;
    end

    assign burst_count = bcnt_q;
`endif

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
module tb_hpdmc_rdcapture;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        read_start = 1'b0;
    logic        rd_ready;
    logic [15:0] di_r = '0, di_f = '0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        err;
`ifdef HPDMC_RDCAPTURE_STATS_EN
    logic [15:0] burst_count;
`endif

    int n_chk = 0, n_fail = 0, n_pops = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    hpdmc_rdcapture #(.CAS_CYCLES(3), .FIFO_DEPTH(8)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .read_start(read_start),
        .rd_ready(rd_ready),
        .di_r(di_r),
        .di_f(di_f),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
`ifdef HPDMC_RDCAPTURE_STATS_EN
        .burst_count(burst_count),
`endif
        .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    function automatic logic [31:0] pat(input int c);
        pat = {16'(c) ^ 16'h5A5A, 16'(c) + 16'h1000};
    endfunction

    task automatic drive_pat(input int c);
        logic [31:0] w;
        w = pat(c);
        di_r = w[31:16];
        di_f = w[15:0];
    endtask

    task automatic do_reset();
        next_cyc();
        sys_rst_n = 1'b0;
        read_start = 1'b0;
        dout_ready = 1'b0;
        repeat (2) next_cyc();
        sys_rst_n = 1'b1;
        sample();
        chk("rdy_after_reset", 32'(rd_ready), 32'd1);
    endtask

    // Scoreboard monitor: every accepted pop must match the oldest expected word.
    always @(negedge sys_clk) begin
        if (sys_rst_n && dout_valid && dout_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got %h expected none", dout);
            end else begin
                mon_e = exp_q.pop_front();
                chk("dout_order", dout, mon_e);
            end
        end
    end

    initial begin
        logic [15:0] tr [4];
        logic [15:0] tf [4];
        int mcount, pops0;
        tr = '{16'h1111, 16'h3333, 16'h5555, 16'h7777};
        tf = '{16'h2222, 16'h4444, 16'h6666, 16'h8888};

        // Reset state
        sample();
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdy", 32'(rd_ready), 32'd0);
        next_cyc();
        sys_rst_n = 1'b1;
        sample();
        chk("rdy_first_cycle", 32'(rd_ready), 32'd1);

        // Single burst with hand-given data
        for (int c = 0; c <= 20; c++) begin
            next_cyc();
            dout_ready = 1'b1;
            read_start = (c == 10);
            if (c >= 13 && c <= 16) begin
                di_r = tr[c-13];
                di_f = tf[c-13];
            end else begin
                di_r = 16'h0;
                di_f = 16'h0;
            end
            if (c == 10) begin
                exp_q.push_back(32'h11112222);
                exp_q.push_back(32'h33334444);
                exp_q.push_back(32'h55556666);
                exp_q.push_back(32'h77778888);
            end
            sample();
            chk("t1_valid", 32'(dout_valid), 32'(c >= 14 && c <= 17));
        end
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Two reads with no consumer; a third start is rejected
        for (int c = 0; c <= 24; c++) begin
            next_cyc();
            dout_ready = 1'b0;
            read_start = (c == 10 || c == 14 || c == 18);
            drive_pat(c);
            if (c == 10 || c == 14)
                for (int k = 3; k < 7; k++) exp_q.push_back(pat(c + k));
            sample();
            if (c >= 10) chk("t2_rdy", 32'(rd_ready), 32'(c == 10 || c == 14));
            if (c == 18) chk("t2_err_before", 32'(err), 32'd0);
            if (c == 19) chk("t2_err_set", 32'(err), 32'd1);
        end
        chk("t2_fifo_words", 32'(exp_q.size()), 32'd8);

        // Full FIFO: one pop, then a start that must not be accepted
        next_cyc();
        read_start = 1'b0;
        dout_ready = 1'b1;
        sample();
        chk("t3_rdy_full", 32'(rd_ready), 32'd0);
        chk("t3_valid_full", 32'(dout_valid), 32'd1);
        next_cyc();
        dout_ready = 1'b0;
        read_start = 1'b1;
        sample();
        chk("t3_rdy_7", 32'(rd_ready), 32'd0);
        mcount = 7;
        for (int c = 0; c < 10; c++) begin
            next_cyc();
            read_start = 1'b0;
            dout_ready = 1'b1;
            sample();
            chk("t3_rdy_track", 32'(rd_ready), 32'(mcount <= 4));
            if (mcount > 0) mcount--;
        end
        chk("t3_empty", 32'(dout_valid), 32'd0);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_err_sticky", 32'(err), 32'd1);

        // 64 back-to-back bursts
        do_reset();
        chk("t4_err_cleared", 32'(err), 32'd0);
        pops0 = n_pops;
        for (int c = 0; c < 256 + 12; c++) begin
            next_cyc();
            dout_ready = 1'b1;
            read_start = (c < 256) && (c % 4 == 0);
            drive_pat(c);
            if (read_start)
                for (int k = 3; k < 7; k++) exp_q.push_back(pat(c + k));
            sample();
            if (c < 256) chk("t4_rdy", 32'(rd_ready), 32'(c % 4 == 0));
        end
        chk("t4_pops", 32'(n_pops - pops0), 32'd256);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_err", 32'(err), 32'd0);
`ifdef HPDMC_RDCAPTURE_STATS_EN
        chk("t4_burst_count", 32'(burst_count), 32'd64);
`endif

        // Reset pulsed mid-burst
        for (int c = 0; c <= 20; c++) begin
            next_cyc();
            dout_ready = 1'b1;
            read_start = (c == 2);
            drive_pat(c);
            if (c == 6) sys_rst_n = 1'b0;
            if (c == 8) sys_rst_n = 1'b1;
            sample();
            chk("t5_valid", 32'(dout_valid), 32'd0);
            if (c >= 6) chk("t5_err", 32'(err), 32'd0);
            if (c == 6 || c == 7) chk("t5_rdy_in_reset", 32'(rd_ready), 32'd0);
            if (c == 8) chk("t5_rdy_release", 32'(rd_ready), 32'd1);
        end
`ifdef HPDMC_RDCAPTURE_STATS_EN
        chk("t5_burst_count", 32'(burst_count), 32'd0);
`endif
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hpdmc_rdcapture.md
HPDMC_RDCAPTURE -- requirements
Module: hpdmc_rdcapture

Interface
REQ-001 Parameter CAS_CYCLES, default 3: sys_clk cycles from an accepted read_start to the first capture cycle; legal range 1..7.
REQ-002 Parameter FIFO_DEPTH, default 8: output FIFO depth in 32-bit words; fixed power of two, at least 4.
REQ-003 sys_clk  input  1: sole clock; all state updates on the rising edge.
REQ-004 sys_rst_n  input  1: reset, asynchronous, active-low.
REQ-005 read_start  input  1: single-cycle pulse; the controller has issued one READ command with a DDR burst of 8 beats.
REQ-006 rd_ready  output  1: a read_start in the same cycle is accepted.
REQ-007 di_r  input  16: rising-edge half from the input DDR registers, valid each cycle.
REQ-008 di_f  input  16: falling-edge half from the input DDR registers, valid each cycle.
REQ-009 dout  output  32: FIFO head word, {di_r, di_f} as captured.
REQ-010 dout_valid  output  1: the FIFO is non-empty and dout holds the head word.
REQ-011 dout_ready  input  1: consumer accepts dout; a pop occurs when dout_valid and dout_ready are both high.
REQ-012 err  output  1: sticky protocol-violation flag.

Function
REQ-013 A read_start is accepted when read_start and rd_ready are both high in cycle t.
REQ-014 Capture cycles for a read accepted in cycle t SHALL be t+CAS_CYCLES through t+CAS_CYCLES+3, giving 4 words per burst.
- Capture cycles are tracked with a shift register of length CAS_CYCLES+4.
REQ-015 In each capture cycle the block SHALL push {di_r, di_f} into the FIFO.
- FIFO is first-word-fall-through.
- dout_valid for a pushed word rises in the following cycle, so the first word is visible in cycle t+CAS_CYCLES+1.
REQ-016 rd_ready = (free FIFO slots - words reserved by accepted reads not yet pushed) >= 4, AND no read accepted in the previous 3 cycles.
REQ-017 Reservation counter rules:
- Increments by 4 on an accepted read_start.
- Decrements by 1 on each push.
- A start in the same cycle as a push changes it by +3.
REQ-018 Simultaneous push and pop SHALL both take effect; occupancy is unchanged and data order is preserved.
REQ-019 A pop while the FIFO is empty SHALL be impossible, because dout_valid is low.
REQ-020 read_start while rd_ready is low SHALL be ignored and SHALL set err; err clears only on reset.
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 Because of REQ-016, a push SHALL never find the FIFO full.
REQ-023 Back-to-back reads spaced exactly 4 cycles SHALL produce contiguous capture windows with no gap and no overlap.

Reset
REQ-024 While sys_rst_n is low, the following SHALL hold:
- FIFO empty, pointers 0, reservation counter 0, shift register cleared.
- dout_valid=0, dout=0, err=0, rd_ready=0.
REQ-025 rd_ready SHALL be 1 in the first cycle after deassertion.
REQ-026 Assertion mid-burst SHALL discard all in-flight captures and FIFO contents; no word is pushed after reset releases.

Configuration
REQ-027 With HPDMC_RDCAPTURE_STATS_EN defined, the following are added:
- Output burst_count[15:0]: saturating count of bursts whose 4th word has been pushed.
- burst_count resets to 0 and holds at 16'hFFFF.
REQ-028 Without HPDMC_RDCAPTURE_STATS_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 CAS_CYCLES=3:
- Stimulus: read_start at cycle 10, di_r/di_f = 16'h1111/2222, 3333/4444, 5555/6666, 7777/8888 in cycles 13..16, dout_ready=1.
- Response: dout = 32'h11112222..77778888 in order, dout_valid high cycles 14..17.
REQ-030 dout_ready=0, two reads at cycles 10 and 14:
- rd_ready low cycles 11..13 and again from 15.
- A third read_start at 18 is ignored and err=1.
- FIFO holds exactly 8 words.
REQ-031 FIFO full, dout_ready=1 for one cycle, then read_start:
- rd_ready stays 0 until 4 slots are unreserved.
REQ-032 Continuous reads every 4 cycles for 64 bursts with dout_ready=1:
- 256 words out, in order, with no loss.
- rd_ready is never low outside the spacing rule.
- With STATS_EN, burst_count=64.
REQ-033 sys_rst_n pulsed low at cycle t+CAS_CYCLES+1 of a burst:
- dout_valid=0, FIFO empty, no further pushes, err=0.
